act_feeder: RTL and testbench
=============================

# act_feeder

Activation feeder that builds full MAC input vectors for the sequential bit-serial accelerator. It collects `inputElements` activations from a narrow write stream into a ping-pong buffer and presents each completed vector on a valid/ready interface that matches the accelerator's `mac_data_i`/`mac_valid_i`/`ready_o` port. It sits between the activation memory/DMA and the accelerator. Because of the two banks, one vector can fill while the previous one waits for the accelerator to accept it.

## Interface
- `maxInputBits`, 8, width of one activation slot.
- `inputElements`, 128, activations per MAC vector.
- `wrWidth`, 32, write beat width; must be a multiple of `maxInputBits`.
- Derived (localparam): `elemsPerBeat = wrWidth/maxInputBits` (4); `beatsPerVec = inputElements/elemsPerBeat` (32; must divide exactly).

Ports:
- `clk` in 1: clock.
- `nrst` in 1: asynchronous, active-low reset.
- `flush_i` in 1: synchronous clear of both banks and any partial vector.
- `wr_data_i` in `wrWidth`: packed activations; element k of the beat is `[k*maxInputBits +: maxInputBits]`.
- `wr_valid_i` in 1: write beat valid.
- `wr_last_i` in 1: beat closes the vector early; remaining slots are zero.
- `wr_ready_o` out 1: feeder can accept a write beat.
- `mac_data_o` out `[inputElements-1:0][maxInputBits-1:0]`: vector for the accelerator.
- `mac_valid_o` out 1: vector valid.
- `mac_ready_i` in 1: accelerator ready.
- `vec_count_o` out 16: vectors handed off since reset or flush; wraps.

## Operation
- State is held in these registers:
  - two banks, each `inputElements × maxInputBits`;
  - `full[1:0]`;
  - `wr_bank` and `rd_bank` (1 bit each);
  - `beat_cnt` (`$clog2(beatsPerVec)` bits);
  - `vec_count`.
- Write acceptance:
  - `wr_ready_o = !full[wr_bank] && !flush_i`.
  - A beat is accepted when `wr_valid_i && wr_ready_o`.
  - It writes slots `beat_cnt*elemsPerBeat … +elemsPerBeat-1` of `wr_bank`.
  - `beat_cnt` then increments.
- Vector close:
  - Triggered on an accepted beat with `beat_cnt == beatsPerVec-1` or `wr_last_i`.
  - Sets `full[wr_bank]`, toggles `wr_bank`, clears `beat_cnt`.
  - `wr_last_i` on the final beat has no extra effect.
- Zero fill: a bank is zeroed whenever it is drained, and at reset/flush. An early-closed vector therefore carries zeros in its unwritten slots.
- Read side:
  - `mac_valid_o = full[rd_bank]`; `mac_data_o` = contents of `rd_bank`.
  - On `mac_valid_o && mac_ready_i`: clear `full[rd_bank]`, zero that bank, toggle `rd_bank`, increment `vec_count`.
- Simultaneous close and drain in one cycle always target different banks (the write bank is not full, the read bank is full). Both take effect.
- `flush_i` has priority over all other updates:
  - zero both banks and `full`, `wr_bank`, `rd_bank`, `beat_cnt`, `vec_count`;
  - any beat presented in that cycle is not accepted.
- Payload is opaque: no sign handling. Two's-complement and bipolar conversion happen downstream in the accelerator.

## Timing
- Reset values: `wr_ready_o=1` once `nrst` deasserts (0 during reset is acceptable only if it derives combinationally from reset-state registers); `mac_valid_o=0`; `mac_data_o=0`; `vec_count_o=0`.
- Latency: the closing beat is accepted in cycle N; `mac_valid_o=1` with the full vector in cycle N+1.
- `mac_data_o` and `mac_valid_o` are stable while `mac_valid_o && !mac_ready_i`.
- The feeder never deasserts `mac_valid_o` without a handshake.
- Both banks full: `wr_ready_o=0` until the next drain. It returns to 1 in the cycle after the drain.
- Steady state: one beat per cycle. Each vector needs `beatsPerVec` cycles, which exceeds the accelerator's per-vector occupancy, so the write side never sees back-pressure in steady state.
- Asynchronous reset mid-vector discards all data, including a partially filled bank.

## Structure
- `qracc_pkg`: add `ACT_WR_WIDTH` default and a typedef `act_vec_t` (`[inputElements-1:0][maxInputBits-1:0]`), shared with the accelerator's `mac_data_i`.
- One natural sub-module: `act_feeder_bank`, a single bank with beat-indexed write and a clear input, instantiated twice. Control (counters, `full`, bank pointers) stays in `act_feeder`.

## Test plan
All scenarios use default parameters.
- **Basic fill:** 32 beats, beat b = `{4{8'(b)}}`, `mac_ready_i=1` → `mac_valid_o` one cycle after beat 31; elements 4b..4b+3 = b; `vec_count_o=1`.
- **Early last:** 3 beats of `32'hA5A5A5A5`, the third with `wr_last_i` → elements 0–11 = `8'hA5`, elements 12–127 = 0.
- **Back-pressure:** `mac_ready_i=0`, stream 3 vectors:
  - `wr_ready_o` drops after 64 accepted beats;
  - `mac_data_o` holds vector 0 unchanged;
  - one `mac_ready_i` pulse → `wr_ready_o=1` the next cycle; vector 1 is presented.
- **Simultaneous:** the closing beat of vector 1 lands in the same cycle as the vector 0 handshake → both complete; vector 1 is valid the next cycle; no data corruption.
- **Flush:** flush mid-vector (beat 10), with one full bank pending → `mac_valid_o=0`, `vec_count_o=0`; the next vector's slots 0–3 come from the first post-flush beat.
- **Async reset:** `nrst` low mid-transfer → outputs at reset values immediately; a subsequent clean vector is delivered correctly.

Source files
------------

// File: rtl/qracc_pkg.sv
// Shared accelerator definitions: activation geometry and the MAC vector type
// used by both the activation feeder and the accelerator's mac_data_i port.
package qracc_pkg;

  localparam int MAX_INPUT_BITS = 8;
  localparam int INPUT_ELEMENTS = 128;
  localparam int ACT_WR_WIDTH   = 32;

  typedef logic [INPUT_ELEMENTS-1:0][MAX_INPUT_BITS-1:0] act_vec_t;

  // Number of write beats that make up one MAC vector.
  function automatic int beats_per_vec(input int elems, input int bits, input int wr_width);
    return elems / (wr_width / bits);
  endfunction

endpackage

// File: rtl/act_feeder_bank.sv
// One activation bank: a full MAC vector written one beat at a time,
// with a synchronous clear that zeroes every slot.
module act_feeder_bank
  import qracc_pkg::*;
#(
  parameter int maxInputBits  = MAX_INPUT_BITS,
  parameter int inputElements = INPUT_ELEMENTS,
  parameter int wrWidth       = ACT_WR_WIDTH,
  parameter int idxWidth      = $clog2(beats_per_vec(inputElements, maxInputBits, wrWidth))
) (
  input  logic                                        clk,
  input  logic                                        nrst,
  input  logic                                        clr_i,
  input  logic                                        wr_en_i,
  input  logic [idxWidth-1:0]                         wr_idx_i,
  input  logic [wrWidth-1:0]                          wr_data_i,
  output logic [inputElements-1:0][maxInputBits-1:0]  data_o
);

  localparam int elemsPerBeat = wrWidth / maxInputBits;
  localparam int beatsPerVec  = inputElements / elemsPerBeat;

  logic [inputElements-1:0][maxInputBits-1:0] data_r;

  // Bank storage: clear wins over a beat write; each beat owns elemsPerBeat slots.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_r <= '0;
    end else if (clr_i) begin
      data_r <= '0;
    end else if (wr_en_i) begin
      for (int b = 0; b < beatsPerVec; b++) begin
        if (wr_idx_i == idxWidth'(b)) begin
          for (int k = 0; k < elemsPerBeat; k++) begin
            data_r[b*elemsPerBeat + k] <= wr_data_i[k*maxInputBits +: maxInputBits];
          end
        end
      end
    end
  end

  assign data_o = data_r;

endmodule

// File: rtl/act_feeder.sv
// Activation feeder: assembles MAC vectors from a narrow write stream into a
// ping-pong pair of banks and hands them to the accelerator over valid/ready.
module act_feeder
  import qracc_pkg::*;
#(
  parameter int maxInputBits  = MAX_INPUT_BITS,
  parameter int inputElements = INPUT_ELEMENTS,
  parameter int wrWidth       = ACT_WR_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        nrst,
  input  logic                                        flush_i,
  input  logic [wrWidth-1:0]                          wr_data_i,
  input  logic                                        wr_valid_i,
  input  logic                                        wr_last_i,
  output logic                                        wr_ready_o,
  output logic [inputElements-1:0][maxInputBits-1:0]  mac_data_o,
  output logic                                        mac_valid_o,
  input  logic                                        mac_ready_i,
  output logic [15:0]                                 vec_count_o
);

  localparam int elemsPerBeat = wrWidth / maxInputBits;
  localparam int beatsPerVec  = inputElements / elemsPerBeat;
  localparam int bcw          = (beatsPerVec > 1) ? $clog2(beatsPerVec) : 1;
  localparam logic [bcw-1:0] BEAT_LAST = bcw'(beatsPerVec - 1);

  logic [1:0]     full_r;
  logic           wr_bank_r;
  logic           rd_bank_r;
  logic [bcw-1:0] beat_cnt_r;
  logic [15:0]    vec_count_r;

  logic           accept_s;
  logic           close_s;
  logic           drain_s;
  logic [1:0]     full_nxt_s;
  logic [1:0]     wen_s;
  logic [1:0]     clr_s;
  logic [inputElements-1:0][maxInputBits-1:0] bank_data_s [2];

  assign wr_ready_o = !full_r[wr_bank_r] && !flush_i;

  // Handshake decode; a flush suppresses both the write and the drain.
  always_comb begin
    accept_s = wr_valid_i && wr_ready_o;
    close_s  = accept_s && ((beat_cnt_r == BEAT_LAST) || wr_last_i);
    drain_s  = full_r[rd_bank_r] && mac_ready_i && !flush_i;
    wen_s[0] = accept_s && !wr_bank_r;
    wen_s[1] = accept_s && wr_bank_r;
    clr_s[0] = flush_i || (drain_s && !rd_bank_r);
    clr_s[1] = flush_i || (drain_s && rd_bank_r);
  end

  // Close and drain always hit different banks, so both updates apply together.
  always_comb begin
    full_nxt_s = full_r;
    if (close_s) begin
      full_nxt_s[wr_bank_r] = 1'b1;
    end else begin
      full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
    end
    if (drain_s) begin
      full_nxt_s[rd_bank_r] = 1'b0;
    end else begin
      full_nxt_s[rd_bank_r] = full_nxt_s[rd_bank_r];
    end
  end

  // Control state: bank pointers, beat counter, full flags and handoff count.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      full_r      <= 2'b00;
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      beat_cnt_r  <= '0;
      vec_count_r <= 16'd0;
    end else if (flush_i) begin
      full_r      <= 2'b00;
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      beat_cnt_r  <= '0;
      vec_count_r <= 16'd0;
    end else begin
      full_r <= full_nxt_s;
      if (close_s) begin
        beat_cnt_r <= '0;
        wr_bank_r  <= !wr_bank_r;
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + bcw'(1);
      end
      if (drain_s) begin
        rd_bank_r   <= !rd_bank_r;
        vec_count_r <= vec_count_r + 16'd1;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    act_feeder_bank #(
      .maxInputBits (maxInputBits),
      .inputElements(inputElements),
      .wrWidth      (wrWidth),
      .idxWidth     (bcw)
    ) u_bank (
      .clk      (clk),
      .nrst     (nrst),
      .clr_i    (clr_s[b]),
      .wr_en_i  (wen_s[b]),
      .wr_idx_i (beat_cnt_r),
      .wr_data_i(wr_data_i),
      .data_o   (bank_data_s[b])
    );
  end

  // Read-side mux: the presented vector is whichever bank rd_bank points at.
  always_comb begin
    if (rd_bank_r) begin
      mac_data_o = bank_data_s[1];
    end else begin
      mac_data_o = bank_data_s[0];
    end
  end

  assign mac_valid_o = full_r[rd_bank_r];
  assign vec_count_o = vec_count_r;

endmodule

// File: tb/tb_act_feeder.sv
// Scoreboard bench for act_feeder: a queue-based reference model predicts
// vectors, write readiness and the handoff count; a monitor compares them.
module tb_act_feeder;
  import qracc_pkg::*;

  localparam int W   = 8;
  localparam int N   = 128;
  localparam int EPB = 4;
  localparam int BPV = 32;

  logic                clk = 1'b0;
  logic                nrst = 1'b0;
  logic                flush_i = 1'b0;
  logic [31:0]         wr_data_i = 32'd0;
  logic                wr_valid_i = 1'b0;
  logic                wr_last_i = 1'b0;
  logic                wr_ready_o;
  logic [N-1:0][W-1:0] mac_data_o;
  logic                mac_valid_o;
  logic                mac_ready_i = 1'b0;
  logic [15:0]         vec_count_o;

  act_feeder dut (
    .clk        (clk),
    .nrst       (nrst),
    .flush_i    (flush_i),
    .wr_data_i  (wr_data_i),
    .wr_valid_i (wr_valid_i),
    .wr_last_i  (wr_last_i),
    .wr_ready_o (wr_ready_o),
    .mac_data_o (mac_data_o),
    .mac_valid_o(mac_valid_o),
    .mac_ready_i(mac_ready_i),
    .vec_count_o(vec_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: completed vectors awaiting handoff, a partial vector.
  logic [N*W-1:0] exp_q[$];
  logic [7:0]     part[N];
  int             part_beats = 0;
  int             m_count = 0;
  bit             acc_flag = 0;
  int             accepted_total = 0;
  bit             rand_ready = 0;

  function automatic logic [N*W-1:0] pack_part();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = part[k];
    return v;
  endfunction

  task automatic clear_part();
    for (int k = 0; k < N; k++) part[k] = 8'd0;
    part_beats = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < N; k++) begin
        if (act[k*W +: W] !== exp[k*W +: W]) begin
          $display("FAIL %s element %0d got %0h expected %0h at %0t",
                   name, k, act[k*W +: W], exp[k*W +: W], $time);
          break;
        end
      end
    end
  endtask

  initial clear_part();

  // Model update on every active edge, from the inputs and the model's own state.
  always @(posedge clk) begin
    acc_flag = 0;
    if (nrst) begin
      if (flush_i) begin
        exp_q.delete();
        clear_part();
        m_count = 0;
      end else begin
        bit rdy;
        rdy = (exp_q.size() < 2);
        if (exp_q.size() > 0 && mac_ready_i) begin
          void'(exp_q.pop_front());
          m_count = (m_count + 1) % 65536;
        end
        if (wr_valid_i && rdy) begin
          for (int k = 0; k < EPB; k++) part[part_beats*EPB + k] = wr_data_i[k*W +: W];
          part_beats++;
          acc_flag = 1;
          accepted_total++;
          if (part_beats == BPV || wr_last_i) begin
            exp_q.push_back(pack_part());
            clear_part();
          end
        end
      end
    end
  end

  // Asynchronous reset discards everything, including a partial vector.
  always @(negedge nrst) begin
    exp_q.delete();
    clear_part();
    m_count = 0;
  end

  // Monitor: compare DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (nrst) begin
      chk("wr_ready", 32'(wr_ready_o), 32'(!flush_i && exp_q.size() < 2));
      chk("mac_valid", 32'(mac_valid_o), 32'(exp_q.size() > 0));
      chk("vec_count", 32'(vec_count_o), 32'(m_count));
      if (exp_q.size() > 0) chk_vec("mac_data", mac_data_o, exp_q[0]);
    end
  end

  // Random accelerator back-pressure when enabled.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      mac_ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last);
    int n;
    n = 0;
    wr_data_i  = d;
    wr_last_i  = last;
    wr_valid_i = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc_flag && n < 300);
    if (!acc_flag) begin
      checks++;
      errors++;
      $display("FAIL beat_accept timed out data %0h", d);
    end
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
  endtask

  task automatic send_rand_beats(input int nb, input bit last_at_end);
    for (int b = 0; b < nb; b++) send_beat($urandom, last_at_end && (b == nb - 1));
  endtask

  task automatic wait_accepted(input int target);
    int n;
    n = 0;
    while (accepted_total < target && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (accepted_total < target) begin
      errors++;
      $display("FAIL wait_accepted got %0d expected %0d", accepted_total, target);
    end
  endtask

  initial begin
    int base;
    #12;
    chk("rst_valid", 32'(mac_valid_o), 32'd0);
    chk("rst_count", 32'(vec_count_o), 32'd0);
    chk_vec("rst_data", mac_data_o, '0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    #1;
    chk("rst_ready", 32'(wr_ready_o), 32'd1);

    // Basic fill
    mac_ready_i = 1'b1;
    for (int b = 0; b < BPV; b++) send_beat({4{8'(b)}}, 1'b0);
    idle(3);
    chk("basic_count", 32'(vec_count_o), 32'd1);

    // Early last
    for (int b = 0; b < 3; b++) send_beat(32'hA5A5A5A5, b == 2);
    idle(3);
    chk("early_count", 32'(vec_count_o), 32'd2);

    // Back-pressure with three vectors
    mac_ready_i = 1'b0;
    base = accepted_total;
    fork
      send_rand_beats(3 * BPV, 1'b0);
    join_none
    wait_accepted(base + 2 * BPV);
    idle(10);
    chk("bp_stall", 32'(wr_ready_o), 32'd0);
    chk("bp_accepted", 32'(accepted_total - base), 32'(2 * BPV));
    mac_ready_i = 1'b1;
    @(posedge clk);
    #1;
    mac_ready_i = 1'b0;
    chk("bp_resume", 32'(wr_ready_o), 32'd1);
    idle(5);
    mac_ready_i = 1'b1;
    wait_accepted(base + 3 * BPV);
    idle(5);

    // Close of vector 1 coincides with handshake of vector 0
    mac_ready_i = 1'b0;
    send_rand_beats(BPV, 1'b0);
    send_rand_beats(BPV - 1, 1'b0);
    idle(2);
    wr_data_i   = $urandom;
    wr_last_i   = 1'b0;
    wr_valid_i  = 1'b1;
    mac_ready_i = 1'b1;
    @(posedge clk);
    #1;
    wr_valid_i  = 1'b0;
    mac_ready_i = 1'b0;
    chk("sim_valid", 32'(mac_valid_o), 32'd1);
    chk("sim_count", 32'(vec_count_o), 32'(m_count));
    idle(2);
    mac_ready_i = 1'b1;
    idle(3);

    // Flush mid-vector with one bank pending
    mac_ready_i = 1'b0;
    send_rand_beats(BPV, 1'b0);
    send_rand_beats(10, 1'b0);
    flush_i    = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_i  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    flush_i    = 1'b0;
    wr_valid_i = 1'b0;
    chk("flush_valid", 32'(mac_valid_o), 32'd0);
    chk("flush_count", 32'(vec_count_o), 32'd0);
    mac_ready_i = 1'b1;
    send_beat(32'h11223344, 1'b0);
    send_rand_beats(BPV - 1, 1'b0);
    idle(3);

    // Asynchronous reset mid-transfer
    mac_ready_i = 1'b0;
    send_rand_beats(BPV, 1'b0);
    wr_valid_i = 1'b1;
    wr_data_i  = $urandom;
    for (int b = 0; b < 10; b++) send_beat($urandom, 1'b0);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_valid", 32'(mac_valid_o), 32'd0);
    chk("arst_count", 32'(vec_count_o), 32'd0);
    chk_vec("arst_data", mac_data_o, '0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    mac_ready_i = 1'b1;
    send_rand_beats(BPV, 1'b0);
    idle(3);
    chk("arst_after", 32'(vec_count_o), 32'd1);

    // Random vectors under random back-pressure
    rand_ready = 1;
    for (int v = 0; v < 20; v++) begin
      int nb;
      nb = $urandom_range(1, BPV);
      send_rand_beats(nb, nb < BPV);
    end
    rand_ready = 0;
    #2;
    mac_ready_i = 1'b1;
    idle(10);
    chk("final_drained", 32'(mac_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
